// File: rtl/display_timing_pkg.sv
// display_timing_pkg: per-axis timing struct, the three supported video
// modes, and the WIDTH -> mode lookup used by display_timing.
package display_timing_pkg;

    // One axis of a video mode; all counts are in pixels (H) or lines (V).
    typedef struct packed {
        logic [11:0] active;
        logic [11:0] fp;
        logic [11:0] sync;
        logic [11:0] bp;
        logic [11:0] total;
        logic        polarity;  // 1 = sync pulse is active-high
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } mode_timing_t;

    localparam mode_timing_t MODE_1080P60 = '{
        h: '{active: 12'd1920, fp: 12'd88,  sync: 12'd44, bp: 12'd148, total: 12'd2200, polarity: 1'b1},
        v: '{active: 12'd1080, fp: 12'd4,   sync: 12'd5,  bp: 12'd36,  total: 12'd1125, polarity: 1'b1}
    };

    localparam mode_timing_t MODE_720P60 = '{
        h: '{active: 12'd1280, fp: 12'd110, sync: 12'd40, bp: 12'd220, total: 12'd1650, polarity: 1'b1},
        v: '{active: 12'd720,  fp: 12'd5,   sync: 12'd5,  bp: 12'd20,  total: 12'd750,  polarity: 1'b1}
    };

    localparam mode_timing_t MODE_480P60 = '{
        h: '{active: 12'd640,  fp: 12'd16,  sync: 12'd96, bp: 12'd48,  total: 12'd800,  polarity: 1'b0},
        v: '{active: 12'd480,  fp: 12'd10,  sync: 12'd2,  bp: 12'd33,  total: 12'd525,  polarity: 1'b0}
    };

    // 3 = 1080p60, 2 = 720p60, anything else falls back to 480p60.
    function automatic mode_timing_t mode_of(input int width);
        mode_timing_t m;
        case (width)
            3:       m = MODE_1080P60;
            2:       m = MODE_720P60;
            default: m = MODE_480P60;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dt_axis_counter.sv
// dt_axis_counter: wrap-around position counter for one display axis.
// cnt_nxt exposes the value cnt takes at the next edge so downstream
// registered controls can line up with the coordinate they describe.
module dt_axis_counter #(
    parameter int W     = 12,
    parameter int TOTAL = 800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // >= rather than == so a corrupted count can never run past TOTAL-1
    assign wrap = en && !clr && (cnt >= LAST);

    // next count: clear wins, then wrap, then increment
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (wrap)
            cnt_nxt = '0;
        else if (en)
            cnt_nxt = cnt + 1'b1;
    end

    // count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/display_timing.sv
// display_timing: raster position and sync/blank generator for 1080p60,
// 720p60 or 480p60 selected by WIDTH. Optional frame counter output is
// enabled by defining DISPLAY_TIMING_FRAME_CNT_EN.
module display_timing
    import display_timing_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_pix_locked,
    output logic [11:0] sx,
    output logic [10:0] sy,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam mode_timing_t MODE = mode_of(WIDTH);
    localparam axis_timing_t HT   = MODE.h;
    localparam axis_timing_t VT   = MODE.v;

    localparam int H_TOTAL = int'(HT.total);
    localparam int V_TOTAL = int'(VT.total);

    localparam logic [11:0] H_SYNC_BEG = HT.active + HT.fp;
    localparam logic [11:0] H_SYNC_END = HT.active + HT.fp + HT.sync;
    localparam logic [11:0] V_SYNC_BEG = VT.active + VT.fp;
    localparam logic [11:0] V_SYNC_END = VT.active + VT.fp + VT.sync;

    // running is low for the first locked cycle, which presents (0,0)
    // with both strobes before counting starts
    logic        running;
    logic        h_en;
    logic        clr;
    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] sx_nxt;
    logic [10:0] sy_nxt;
    logic [11:0] sy_nxt_ext;
    logic        h_in_sync;
    logic        v_in_sync;

    assign clr        = ~clk_pix_locked;
    assign h_en       = clk_pix_locked & running;
    assign sy_nxt_ext = {1'b0, sy_nxt};
    assign h_in_sync  = (sx_nxt >= H_SYNC_BEG) && (sx_nxt < H_SYNC_END);
    assign v_in_sync  = (sy_nxt_ext >= V_SYNC_BEG) && (sy_nxt_ext < V_SYNC_END);

    dt_axis_counter #(.W(12), .TOTAL(H_TOTAL)) u_hcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (h_en),
        .clr     (clr),
        .cnt     (sx),
        .cnt_nxt (sx_nxt),
        .wrap    (h_wrap)
    );

    dt_axis_counter #(.W(11), .TOTAL(V_TOTAL)) u_vcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (h_wrap),
        .clr     (clr),
        .cnt     (sy),
        .cnt_nxt (sy_nxt),
        .wrap    (v_wrap)
    );

    // controls are computed from the next coordinates so they land in the
    // same cycle as the (sx,sy) they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running     <= 1'b0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HT.polarity;
            vsync       <= ~VT.polarity;
        end else if (!clk_pix_locked) begin
            running     <= 1'b0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HT.polarity;
            vsync       <= ~VT.polarity;
        end else begin
            running     <= 1'b1;
            de          <= (sx_nxt < HT.active) && (sy_nxt_ext < VT.active);
            line_start  <= h_wrap | ~running;
            frame_start <= v_wrap | ~running;
            hsync       <= h_in_sync ? HT.polarity : ~HT.polarity;
            vsync       <= v_in_sync ? VT.polarity : ~VT.polarity;
        end
    end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    // frame counter: advances on each vertical wrap, free-wraps at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_cnt <= '0;
        else if (v_wrap)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_display_timing.sv
// tb_display_timing: directed checks of display_timing in all three modes
// (WIDTH=1/2/3 side by side), including lock drop, mid-line reset and the
// optional DISPLAY_TIMING_FRAME_CNT_EN frame counter.
module tb_display_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lk1 = 1'b0, lk2 = 1'b0, lk3 = 1'b0;
    logic [11:0] sx1, sx2, sx3;
    logic [10:0] sy1, sy2, sy3;
    logic hs1, hs2, hs3, vs1, vs2, vs3, de1, de2, de3;
    logic ls1, ls2, ls3, fs1, fs2, fs3;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [15:0] fc1, fc2, fc3;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    display_timing #(.WIDTH(1)) u_d1 (
        .clk(clk), .rst(rst), .clk_pix_locked(lk1), .sx(sx1), .sy(sy1),
        .hsync(hs1), .vsync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    display_timing #(.WIDTH(2)) u_d2 (
        .clk(clk), .rst(rst), .clk_pix_locked(lk2), .sx(sx2), .sy(sy2),
        .hsync(hs2), .vsync(vs2), .de(de2), .line_start(ls2), .frame_start(fs2)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc2)
`endif
    );

    display_timing #(.WIDTH(3)) u_d3 (
        .clk(clk), .rst(rst), .clk_pix_locked(lk3), .sx(sx3), .sy(sy3),
        .hsync(hs3), .vsync(vs3), .de(de3), .line_start(ls3), .frame_start(fs3)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc3)
`endif
    );

    // index the three DUTs by mode number for the table-driven loops
    logic [11:0] sxv [1:3];
    logic [10:0] syv [1:3];
    logic        hsv [1:3];
    logic        vsv [1:3];
    logic        dev [1:3];
    logic        lsv [1:3];
    assign sxv[1] = sx1; assign sxv[2] = sx2; assign sxv[3] = sx3;
    assign syv[1] = sy1; assign syv[2] = sy2; assign syv[3] = sy3;
    assign hsv[1] = hs1; assign hsv[2] = hs2; assign hsv[3] = hs3;
    assign vsv[1] = vs1; assign vsv[2] = vs2; assign vsv[3] = vs3;
    assign dev[1] = de1; assign dev[2] = de2; assign dev[3] = de3;
    assign lsv[1] = ls1; assign lsv[2] = ls2; assign lsv[3] = ls3;

    // hand-computed per-mode expectations: 480p, 720p, 1080p
    int exp_len [1:3] = '{800, 1650, 2200};
    int exp_hlo [1:3] = '{656, 1390, 2008};
    int exp_hhi [1:3] = '{751, 1429, 2051};
    int exp_hn  [1:3] = '{96, 40, 44};
    int exp_de  [1:3] = '{640, 1280, 1920};

    int len [1:3];
    int hn  [1:3];
    int hlo [1:3];
    int hhi [1:3];
    int den [1:3];
    int vlo [1:3];
    int vhi [1:3];
    logic pvs [1:3];
    int vbad, vde, psx, psy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, before any clock edge
        #1 rst = 1'b0;
        #2;
        chk("rst_sx1", sx1, 0);
        chk("rst_sy1", sy1, 0);
        chk("rst_de1", de1, 0);
        chk("rst_hs1", hs1, 1);
        chk("rst_vs1", vs1, 1);
        chk("rst_ls1", ls1, 0);
        chk("rst_fs1", fs1, 0);
        chk("rst_hs3", hs3, 0);

        step();
        rst = 1'b1;
        step();
        chk("idle_sx1", sx1, 0);
        chk("idle_ls1", ls1, 0);

        // lock sampled at cycle 10
        while (cyc < 9) step();
        lk1 = 1'b1; lk2 = 1'b1; lk3 = 1'b1;
        step();
        chk("lock_sx1", sx1, 0);
        chk("lock_sy1", sy1, 0);
        chk("lock_ls1", ls1, 1);
        chk("lock_fs1", fs1, 1);
        chk("lock_de1", de1, 1);
        chk("lock_hs1", hs1, 1);
        chk("lock_fs3", fs3, 1);

        // one full line of each mode: line length, hsync window, de width
        for (int d = 1; d <= 3; d++) begin
            len[d] = 0; hn[d] = 0; hlo[d] = 9999; hhi[d] = -1; den[d] = 0;
        end
        for (int i = 0; i <= 2200; i++) begin
            if (i > 0) step();
            for (int d = 1; d <= 3; d++) begin
                if (i > 0 && lsv[d] && len[d] == 0) len[d] = i;
                if (syv[d] == 0) begin
                    if (hsv[d] == (d != 1)) begin
                        hn[d]++;
                        if (int'(sxv[d]) < hlo[d]) hlo[d] = int'(sxv[d]);
                        hhi[d] = int'(sxv[d]);
                    end
                    if (dev[d]) den[d]++;
                end
            end
        end
        for (int d = 1; d <= 3; d++) begin
            chk($sformatf("line_len%0d", d), len[d], exp_len[d]);
            chk($sformatf("hs_first%0d", d), hlo[d], exp_hlo[d]);
            chk($sformatf("hs_last%0d", d), hhi[d], exp_hhi[d]);
            chk($sformatf("hs_width%0d", d), hn[d], exp_hn[d]);
            chk($sformatf("de_width%0d", d), den[d], exp_de[d]);
        end
        chk("line2_sx3", sx3, 0);
        chk("line2_sy3", sy3, 1);

        // vertical sync windows: jump near the sync region
        @(negedge clk);
        force u_d2.u_vcnt.cnt = 11'd724;
        force u_d3.u_vcnt.cnt = 11'd1083;
        step();
        release u_d2.u_vcnt.cnt;
        release u_d3.u_vcnt.cnt;
        chk("jump_sy2", sy2, 724);
        chk("jump_sy3", sy3, 1083);
        for (int d = 2; d <= 3; d++) begin
            vlo[d] = 9999; vhi[d] = -1; pvs[d] = vsv[d];
        end
        vbad = 0; vde = 0;
        for (int k = 0; k < 16000 && sy3 != 11'd1090; k++) begin
            step();
            for (int d = 2; d <= 3; d++) begin
                if (vsv[d]) begin
                    if (int'(syv[d]) < vlo[d]) vlo[d] = int'(syv[d]);
                    if (int'(syv[d]) > vhi[d]) vhi[d] = int'(syv[d]);
                end
                if (vsv[d] != pvs[d] && sxv[d] != 0) vbad++;
                pvs[d] = vsv[d];
            end
            if (de2 || de3) vde++;
        end
        chk("reach_sy3", sy3, 1090);
        chk("vs_first2", vlo[2], 725);
        chk("vs_last2", vhi[2], 729);
        chk("vs_first3", vlo[3], 1084);
        chk("vs_last3", vhi[3], 1088);
        chk("vs_midline", vbad, 0);
        chk("vblank_de", vde, 0);

        // 1080p frame wrap 2199/1124 -> 0/0
        @(negedge clk);
        force u_d3.u_vcnt.cnt = 11'd1124;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        force u_d3.frame_cnt = 16'hFFFF;
`endif
        step();
        release u_d3.u_vcnt.cnt;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        release u_d3.frame_cnt;
        chk("fcnt_pre3", fc3, 16'hFFFF);
`endif
        psx = int'(sx3); psy = int'(sy3);
        for (int k = 0; k < 2300 && sx3 != 0; k++) begin
            psx = int'(sx3); psy = int'(sy3);
            step();
        end
        chk("wrap_psx3", psx, 2199);
        chk("wrap_psy3", psy, 1124);
        chk("wrap_sx3", sx3, 0);
        chk("wrap_sy3", sy3, 0);
        chk("wrap_fs3", fs3, 1);
        chk("wrap_ls3", ls3, 1);
        chk("wrap_de3", de3, 1);
        chk("wrap_vs3", vs3, 0);
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        chk("fcnt_wrap3", fc3, 0);
`endif

        // lock drop on 480p at (500,300), then relock
        for (int k = 0; k < 900 && sx1 != 12'd10; k++) step();
        chk("reach_sx10", sx1, 10);
        @(negedge clk);
        force u_d1.u_vcnt.cnt = 11'd300;
        step();
        release u_d1.u_vcnt.cnt;
        for (int k = 0; k < 900 && sx1 != 12'd500; k++) step();
        chk("drop_at_sx", sx1, 500);
        chk("drop_at_sy", sy1, 300);
        chk("drop_at_de", de1, 1);
        lk1 = 1'b0;
        step();
        chk("drop_sx1", sx1, 0);
        chk("drop_sy1", sy1, 0);
        chk("drop_de1", de1, 0);
        chk("drop_ls1", ls1, 0);
        chk("drop_fs1", fs1, 0);
        chk("drop_hs1", hs1, 1);
        chk("drop_vs1", vs1, 1);
        repeat (3) step();
        chk("hold_sx1", sx1, 0);
        chk("hold_ls1", ls1, 0);
        lk1 = 1'b1;
        step();
        chk("relock_sx1", sx1, 0);
        chk("relock_sy1", sy1, 0);
        chk("relock_fs1", fs1, 1);
        chk("relock_ls1", ls1, 1);
        step();
        chk("run_sx1", sx1, 1);
        chk("run_fs1", fs1, 0);
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        chk("fcnt_held1", fc1, 0);
`endif

        // asynchronous reset between edges mid-line
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_sx3", sx3, 0);
        chk("arst_sy3", sy3, 0);
        chk("arst_de3", de3, 0);
        chk("arst_ls3", ls3, 0);
        chk("arst_fs3", fs3, 0);
        chk("arst_hs3", hs3, 0);
        chk("arst_vs3", vs3, 0);
        chk("arst_hs1", hs1, 1);
        chk("arst_sx2", sx2, 0);
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        chk("arst_fcnt3", fc3, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_fs3", fs3, 1);
        chk("rel_sx3", sx3, 0);
        chk("rel_fs1", fs1, 1);
        step();
        chk("rel_run_sx3", sx3, 1);
        chk("rel_run_fs3", fs3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
